fetch_seq_ctrl: RTL and testbench

- Sequencing controller for the instruction-fetch PC unit; sole driver of its Init, Stall, done, Branch, Target and exp_error inputs.
- Runs a program lifecycle: idle, init, run, memory-wait, exception flush, done.
- Arbitrates same-cycle exception, halt, memory, hazard and branch requests into one consistent fetch command per cycle.
- Keeps a run-cycle counter for the bench and the top level.

---
 rtl/fetch_seq_ctrl_pkg.sv | 16 +
 rtl/fetch_seq_ctrl_if.sv | 32 +++
 rtl/fetch_seq_ctrl_wait_timer.sv | 19 +
 rtl/fetch_seq_ctrl.sv | 98 +++++++++
 tb/tb_fetch_seq_ctrl.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/fetch_seq_ctrl_pkg.sv
// fetch_seq_ctrl_pkg: shared state encoding, exception codes and default widths
package fetch_seq_ctrl_pkg;
   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_INIT    = 3'd1,
      S_RUN     = 3'd2,
      S_MEMWAIT = 3'd3,
      S_EXC     = 3'd4,
      S_DONE    = 3'd5
   } state_t;
   localparam logic [1:0] EXC_NONE = 2'b00;
   localparam logic [1:0] EXC_POS  = 2'b01;
   localparam logic [1:0] EXC_NEG  = 2'b10;
   localparam int TGT_W_DEF = 3;
   localparam int CYC_W_DEF = 16;
endpackage

// File: rtl/fetch_seq_ctrl_if.sv
// fetch_seq_ctrl_if: request inputs and fetch commands between decode/fetch and the sequencer
interface fetch_seq_ctrl_if
   import fetch_seq_ctrl_pkg::*;
#(
   parameter int TGT_W = TGT_W_DEF,
   parameter int CYC_W = CYC_W_DEF
);
   logic             Start;
   logic             Halt_dec;
   logic             Br_req;
   logic [TGT_W-1:0] Br_tgt;
   logic             Hazard;
   logic             Mem_req;
   logic [1:0]       Exp_in;
   logic             Init;
   logic             Stall;
   logic             done;
   logic             Branch;
   logic [TGT_W-1:0] Target;
   logic [1:0]       exp_error;
   logic             Busy;
   logic [CYC_W-1:0] Cycles;
   logic             Exc_seen;
   modport master (
      output Start, Halt_dec, Br_req, Br_tgt, Hazard, Mem_req, Exp_in,
      input  Init, Stall, done, Branch, Target, exp_error, Busy, Cycles, Exc_seen
   );
   modport slave (
      input  Start, Halt_dec, Br_req, Br_tgt, Hazard, Mem_req, Exp_in,
      output Init, Stall, done, Branch, Target, exp_error, Busy, Cycles, Exc_seen
   );
endinterface

// File: rtl/fetch_seq_ctrl_wait_timer.sv
// fetch_wait_timer: loadable down-counter with zero flag for memory-wait stalls
module fetch_wait_timer #(
   parameter int W = 1
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_load,
   input  logic [W-1:0] i_val,
   output logic         o_zero
);
   logic [W-1:0] r_cnt;
   // load wins over decrement; counting stops at zero
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_cnt <= '0;
      else if (i_load) r_cnt <= i_val;
      else if (!o_zero) r_cnt <= r_cnt - 1'b1;
   end
   assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/fetch_seq_ctrl.sv
// fetch_seq_ctrl: program lifecycle FSM arbitrating requests into one fetch command per cycle
module fetch_seq_ctrl
   import fetch_seq_ctrl_pkg::*;
#(
   parameter int TGT_W   = TGT_W_DEF,
   parameter int MEM_LAT = 2,
   parameter int CYC_W   = CYC_W_DEF
) (
   input  logic             CLK,
   input  logic             Reset_n,
   fetch_seq_ctrl_if.slave  bus
);
   localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'((MEM_LAT > 0) ? MEM_LAT - 1 : 0);
   state_t           r_state;
   state_t           w_next;
   logic [CYC_W-1:0] r_cycles;
   logic             r_exc_seen;
   logic             w_stall;
   logic             w_branch;
   logic [1:0]       w_exp;
   logic             w_load;
   logic             w_zero;
   logic             w_exc;
   assign w_exc = (r_state == S_RUN) && (bus.Exp_in == EXC_POS || bus.Exp_in == EXC_NEG);
   fetch_wait_timer #(.W(CNT_W)) u_timer (
      .i_clk   (CLK),
      .i_rst_n (Reset_n),
      .i_load  (w_load),
      .i_val   (LOAD_VAL),
      .o_zero  (w_zero)
   );
   // state register
   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) r_state <= S_IDLE;
      else r_state <= w_next;
   end
   // next state and per-cycle fetch command; exception > halt > memory > hazard > branch
   always_comb begin
      w_next   = r_state;
      w_stall  = 1'b0;
      w_branch = 1'b0;
      w_exp    = EXC_NONE;
      w_load   = 1'b0;
      case (r_state)
         S_IDLE, S_DONE: w_next = bus.Start ? S_INIT : r_state;
         S_INIT: w_next = S_RUN;
         S_RUN: begin
            if (w_exc) begin
               w_exp  = bus.Exp_in;
               w_next = S_EXC;
            end else if (bus.Halt_dec) begin
               w_next = S_DONE;
            end else if (bus.Mem_req) begin
               w_branch = bus.Br_req;
               w_load   = (MEM_LAT != 0);
               w_next   = (MEM_LAT != 0) ? S_MEMWAIT : S_RUN;
            end else if (bus.Hazard) begin
               w_stall = 1'b1;
            end else begin
               w_branch = bus.Br_req;
            end
         end
         S_MEMWAIT: begin
            w_stall = 1'b1;
            w_next  = w_zero ? S_RUN : S_MEMWAIT;
         end
         S_EXC: begin
            w_stall = 1'b1;
            w_next  = S_RUN;
         end
         default: w_next = S_IDLE;
      endcase
   end
   // run-cycle counter and sticky exception flag, both cleared on entry to INIT
   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         r_cycles   <= '0;
         r_exc_seen <= 1'b0;
      end else if (w_next == S_INIT) begin
         r_cycles   <= '0;
         r_exc_seen <= 1'b0;
      end else begin
         if ((r_state == S_RUN || r_state == S_MEMWAIT || r_state == S_EXC) && r_cycles != '1)
            r_cycles <= r_cycles + 1'b1;
         if (w_exc) r_exc_seen <= 1'b1;
      end
   end
   assign bus.Init      = (r_state == S_INIT);
   assign bus.done      = (r_state == S_IDLE) || (r_state == S_DONE);
   assign bus.Busy      = (r_state == S_INIT) || (r_state == S_RUN) || (r_state == S_MEMWAIT) || (r_state == S_EXC);
   assign bus.Stall     = w_stall;
   assign bus.Branch    = w_branch;
   assign bus.Target    = w_branch ? bus.Br_tgt : '0;
   assign bus.exp_error = w_exp;
   assign bus.Cycles    = r_cycles;
   assign bus.Exc_seen  = r_exc_seen;
endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// tb_fetch_seq_ctrl: directed self-checking bench for the fetch sequencing controller
module tb_fetch_seq_ctrl;
   logic CLK = 1'b0;
   logic Reset_n = 1'b1;
   int   checks = 0;
   int   errors = 0;
   fetch_seq_ctrl_if #(.TGT_W(3), .CYC_W(16)) a_if ();
   fetch_seq_ctrl_if #(.TGT_W(3), .CYC_W(16)) b_if ();
   fetch_seq_ctrl #(.TGT_W(3), .MEM_LAT(2), .CYC_W(16)) u_dut (
      .CLK (CLK), .Reset_n (Reset_n), .bus (a_if)
   );
   fetch_seq_ctrl #(.TGT_W(3), .MEM_LAT(0), .CYC_W(16)) u_dut0 (
      .CLK (CLK), .Reset_n (Reset_n), .bus (b_if)
   );
   assign b_if.Start    = a_if.Start;
   assign b_if.Halt_dec = a_if.Halt_dec;
   assign b_if.Br_req   = a_if.Br_req;
   assign b_if.Br_tgt   = a_if.Br_tgt;
   assign b_if.Hazard   = a_if.Hazard;
   assign b_if.Mem_req  = a_if.Mem_req;
   assign b_if.Exp_in   = a_if.Exp_in;
   always #5 CLK = ~CLK;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask
   initial begin
      a_if.Start = 0; a_if.Halt_dec = 0; a_if.Br_req = 0; a_if.Br_tgt = 0;
      a_if.Hazard = 0; a_if.Mem_req = 0; a_if.Exp_in = 2'b00;
      #1 Reset_n = 1'b0;
      #1;
      chk("rst_done", a_if.done, 1);
      chk("rst_busy", a_if.Busy, 0);
      chk("rst_init", a_if.Init, 0);
      chk("rst_stall", a_if.Stall, 0);
      chk("rst_branch", a_if.Branch, 0);
      chk("rst_target", a_if.Target, 0);
      chk("rst_exp", a_if.exp_error, 0);
      chk("rst_cycles", a_if.Cycles, 0);
      chk("rst_excseen", a_if.Exc_seen, 0);
      Reset_n = 1'b1;
      a_if.Start = 1;
      tick();
      a_if.Start = 0;
      #1;
      chk("init_pulse", a_if.Init, 1);
      chk("init_busy", a_if.Busy, 1);
      chk("init_done", a_if.done, 0);
      tick();
      chk("run_init_low", a_if.Init, 0);
      chk("run_busy", a_if.Busy, 1);
      chk("run_done", a_if.done, 0);
      chk("run_cycles0", a_if.Cycles, 0);
      for (int i = 0; i < 5; i++) tick();
      chk("run_cycles5", a_if.Cycles, 5);
      a_if.Start = 1;
      tick();
      a_if.Start = 0;
      #1;
      chk("start_in_run_init", a_if.Init, 0);
      chk("start_in_run_busy", a_if.Busy, 1);
      a_if.Mem_req = 1; a_if.Br_req = 1; a_if.Br_tgt = 3;
      #1;
      chk("mem_stall", a_if.Stall, 0);
      chk("mem_branch", a_if.Branch, 1);
      chk("mem_target", a_if.Target, 3);
      chk("mem0_branch", b_if.Branch, 1);
      tick();
      a_if.Mem_req = 0; a_if.Br_req = 1; a_if.Br_tgt = 6; a_if.Hazard = 1;
      #1;
      chk("memwait1_stall", a_if.Stall, 1);
      chk("memwait1_branch", a_if.Branch, 0);
      chk("memwait1_target", a_if.Target, 0);
      chk("mem0_stall", b_if.Stall, 1);
      a_if.Hazard = 0;
      #1;
      chk("mem0_nostall", b_if.Stall, 0);
      chk("mem0_target", b_if.Target, 6);
      tick();
      a_if.Br_req = 0;
      #1;
      chk("memwait2_stall", a_if.Stall, 1);
      tick();
      chk("memwait_end_stall", a_if.Stall, 0);
      chk("memwait_end_busy", a_if.Busy, 1);
      chk("memwait_cycles", a_if.Cycles, 9);
      a_if.Exp_in = 2'b01; a_if.Hazard = 1; a_if.Br_req = 1; a_if.Br_tgt = 5;
      #1;
      chk("exc_code", a_if.exp_error, 2'b01);
      chk("exc_stall", a_if.Stall, 0);
      chk("exc_branch", a_if.Branch, 0);
      chk("exc_target", a_if.Target, 0);
      tick();
      a_if.Exp_in = 2'b00; a_if.Hazard = 0; a_if.Br_req = 0;
      #1;
      chk("flush_stall", a_if.Stall, 1);
      chk("flush_exp", a_if.exp_error, 0);
      chk("flush_excseen", a_if.Exc_seen, 1);
      tick();
      a_if.Exp_in = 2'b11;
      #1;
      chk("exp11_code", a_if.exp_error, 0);
      chk("exp11_stall", a_if.Stall, 0);
      tick();
      a_if.Exp_in = 2'b00;
      #1;
      chk("exp11_still_run", a_if.Stall, 0);
      a_if.Hazard = 1; a_if.Br_req = 1; a_if.Br_tgt = 5;
      #1;
      chk("haz_stall", a_if.Stall, 1);
      chk("haz_branch", a_if.Branch, 0);
      tick();
      a_if.Hazard = 0;
      #1;
      chk("br_branch", a_if.Branch, 1);
      chk("br_target", a_if.Target, 5);
      chk("br_stall", a_if.Stall, 0);
      tick();
      a_if.Br_req = 0; a_if.Halt_dec = 1; a_if.Br_req = 1;
      #1;
      chk("halt_branch", a_if.Branch, 0);
      chk("halt_stall", a_if.Stall, 0);
      tick();
      a_if.Halt_dec = 0; a_if.Br_req = 0;
      #1;
      chk("done_flag", a_if.done, 1);
      chk("done_busy", a_if.Busy, 0);
      chk("done_cycles", a_if.Cycles, 15);
      tick();
      tick();
      chk("done_cycles_frozen", a_if.Cycles, 15);
      chk("done_excseen", a_if.Exc_seen, 1);
      a_if.Start = 1;
      tick();
      a_if.Start = 0;
      #1;
      chk("restart_init", a_if.Init, 1);
      chk("restart_cycles", a_if.Cycles, 0);
      chk("restart_excseen", a_if.Exc_seen, 0);
      tick();
      a_if.Exp_in = 2'b10;
      #1;
      chk("exc_neg_code", a_if.exp_error, 2'b10);
      tick();
      a_if.Exp_in = 2'b00;
      tick();
      chk("exc_neg_cycles", a_if.Cycles, 2);
      a_if.Mem_req = 1;
      tick();
      a_if.Mem_req = 0;
      #1;
      chk("pre_rst_stall", a_if.Stall, 1);
      Reset_n = 1'b0;
      #1;
      chk("midrst_stall", a_if.Stall, 0);
      chk("midrst_done", a_if.done, 1);
      chk("midrst_busy", a_if.Busy, 0);
      chk("midrst_cycles", a_if.Cycles, 0);
      Reset_n = 1'b1;
      tick();
      chk("post_rst_idle", a_if.done, 1);
      chk("post_rst_init", a_if.Init, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
